// File: rtl/excp_ctrl.sv
// Machine-mode trap sequencer: detects exceptions, the timer interrupt and mret
// in decode, writes the trap CSRs one per cycle, then redirects fetch.
module excp_ctrl #(
   parameter int DW          = 32,
   parameter bit VECTORED_EN = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          id_valid_i,
   input  logic [DW-1:0] id_pc_i,
   input  logic [31:0]   id_inst_i,
   input  logic          id_ecall_i,
   input  logic          id_ebreak_i,
   input  logic          id_illegal_i,
   input  logic          id_mret_i,
   input  logic          irq_timer_i,
   input  logic [DW-1:0] csr_mstatus_i,
   input  logic [DW-1:0] csr_mie_i,
   input  logic [DW-1:0] csr_mtvec_i,
   input  logic [DW-1:0] csr_mepc_i,
   output logic          csr_we_o,
   output logic [11:0]   csr_waddr_o,
   output logic [DW-1:0] csr_wdata_o,
   output logic          excp_stallreq_o,
   output logic [2:0]    excp_flushreq_o,
   output logic          excp_jump_o,
   output logic [DW-1:0] excp_jump_addr_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_W_MEPC, S_W_MCAUSE, S_W_MTVAL, S_W_MSTATUS, S_JUMP
   } state_t;

   typedef enum logic [1:0] {K_NONE, K_EXC, K_IRQ, K_MRET} kind_t;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
   localparam logic [11:0] ADDR_MTVAL   = 12'h343;

   state_t        state, state_nxt;
   kind_t         kind, det_kind;
   logic [DW-1:0] pc, cause, tval;
   logic [DW-1:0] det_cause, det_tval;
   logic          irq_take, detect;
   logic [DW-1:0] mstatus_trap, mstatus_mret, trap_base;

   // Only MTIE is consulted from mie.
   logic unused_mie;
   assign unused_mie = ^{csr_mie_i[DW-1:8], csr_mie_i[6:0]};

   assign irq_take = irq_timer_i & csr_mstatus_i[3] & csr_mie_i[7];

   // NOTE: every comb output gets a default first so no path can infer a latch.
   always_comb begin
      det_kind  = K_NONE;
      det_cause = '0;
      det_tval  = '0;
      if (id_illegal_i) begin
         det_kind  = K_EXC;
         det_cause = DW'(2);
         det_tval  = DW'(id_inst_i);
      end else if (id_ebreak_i) begin
         det_kind  = K_EXC;
         det_cause = DW'(3);
         det_tval  = id_pc_i;
      end else if (id_ecall_i) begin
         det_kind  = K_EXC;
         det_cause = DW'(11);
      end else if (irq_take) begin
         det_kind  = K_IRQ;
         det_cause = {1'b1, (DW-1)'(7)};
      end else if (id_mret_i) begin
         det_kind  = K_MRET;
      end
   end

   assign detect = (state == S_IDLE) && id_valid_i && (det_kind != K_NONE);

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= S_IDLE;
         kind  <= K_NONE;
         pc    <= '0;
         cause <= '0;
         tval  <= '0;
      end else begin
         state <= state_nxt;
         if (detect) begin
            kind  <= det_kind;
            pc    <= id_pc_i;
            cause <= det_cause;
            tval  <= det_tval;
         end
      end
   end

   always_comb begin
      mstatus_trap        = csr_mstatus_i;
      mstatus_trap[7]     = csr_mstatus_i[3];
      mstatus_trap[3]     = 1'b0;
      mstatus_trap[12:11] = 2'b11;
      mstatus_mret        = csr_mstatus_i;
      mstatus_mret[3]     = csr_mstatus_i[7];
      mstatus_mret[7]     = 1'b1;
   end

   assign trap_base = {csr_mtvec_i[DW-1:2], 2'b00};

   always_comb begin
      state_nxt        = state;
      csr_we_o         = 1'b0;
      csr_waddr_o      = '0;
      csr_wdata_o      = '0;
      excp_stallreq_o  = 1'b0;
      excp_flushreq_o  = 3'b000;
      excp_jump_o      = 1'b0;
      excp_jump_addr_o = '0;
      unique case (state)
         S_IDLE: begin
            if (detect) begin
               excp_stallreq_o = 1'b1;
               state_nxt       = (det_kind == K_MRET) ? S_W_MSTATUS : S_W_MEPC;
            end
         end
         S_W_MEPC: begin
            excp_stallreq_o = 1'b1;
            csr_we_o        = 1'b1;
            csr_waddr_o     = ADDR_MEPC;
            csr_wdata_o     = pc;
            state_nxt       = S_W_MCAUSE;
         end
         S_W_MCAUSE: begin
            excp_stallreq_o = 1'b1;
            csr_we_o        = 1'b1;
            csr_waddr_o     = ADDR_MCAUSE;
            csr_wdata_o     = cause;
            state_nxt       = S_W_MTVAL;
         end
         S_W_MTVAL: begin
            excp_stallreq_o = 1'b1;
            csr_we_o        = 1'b1;
            csr_waddr_o     = ADDR_MTVAL;
            csr_wdata_o     = tval;
            state_nxt       = S_W_MSTATUS;
         end
         S_W_MSTATUS: begin
            excp_stallreq_o = 1'b1;
            csr_we_o        = 1'b1;
            csr_waddr_o     = ADDR_MSTATUS;
            csr_wdata_o     = (kind == K_MRET) ? mstatus_mret : mstatus_trap;
            state_nxt       = S_JUMP;
         end
         S_JUMP: begin
            excp_jump_o = 1'b1;
            state_nxt   = S_IDLE;
            case (kind)
               K_MRET: begin
                  excp_flushreq_o  = 3'b100;
                  excp_jump_addr_o = csr_mepc_i;
               end
               K_IRQ: begin
                  excp_flushreq_o  = 3'b001;
                  excp_jump_addr_o = (VECTORED_EN && csr_mtvec_i[1:0] == 2'b01)
                                     ? trap_base + DW'(28) : trap_base;
               end
               default: begin
                  excp_flushreq_o  = 3'b010;
                  excp_jump_addr_o = trap_base;
               end
            endcase
         end
         default: state_nxt = S_IDLE;
      endcase
      // Suppress any in-flight write during the reset cycle itself.
      if (rst_i) begin
         state_nxt        = S_IDLE;
         csr_we_o         = 1'b0;
         csr_waddr_o      = '0;
         csr_wdata_o      = '0;
         excp_stallreq_o  = 1'b0;
         excp_flushreq_o  = 3'b000;
         excp_jump_o      = 1'b0;
         excp_jump_addr_o = '0;
      end
   end

endmodule

// File: tb/tb_excp_ctrl.sv
// Directed self-checking bench for excp_ctrl: trap, interrupt, mret,
// priority, back-to-back and mid-sequence reset scenarios.
module tb_excp_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        id_valid_i;
   logic [31:0] id_pc_i;
   logic [31:0] id_inst_i;
   logic        id_ecall_i, id_ebreak_i, id_illegal_i, id_mret_i;
   logic        irq_timer_i;
   logic [31:0] csr_mstatus_i, csr_mie_i, csr_mtvec_i, csr_mepc_i;
   logic        csr_we_o;
   logic [11:0] csr_waddr_o;
   logic [31:0] csr_wdata_o;
   logic        excp_stallreq_o;
   logic [2:0]  excp_flushreq_o;
   logic        excp_jump_o;
   logic [31:0] excp_jump_addr_o;

   int n_checks = 0;
   int n_fail   = 0;

   excp_ctrl #(.DW(32), .VECTORED_EN(1'b1)) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .id_valid_i      (id_valid_i),
      .id_pc_i         (id_pc_i),
      .id_inst_i       (id_inst_i),
      .id_ecall_i      (id_ecall_i),
      .id_ebreak_i     (id_ebreak_i),
      .id_illegal_i    (id_illegal_i),
      .id_mret_i       (id_mret_i),
      .irq_timer_i     (irq_timer_i),
      .csr_mstatus_i   (csr_mstatus_i),
      .csr_mie_i       (csr_mie_i),
      .csr_mtvec_i     (csr_mtvec_i),
      .csr_mepc_i      (csr_mepc_i),
      .csr_we_o        (csr_we_o),
      .csr_waddr_o     (csr_waddr_o),
      .csr_wdata_o     (csr_wdata_o),
      .excp_stallreq_o (excp_stallreq_o),
      .excp_flushreq_o (excp_flushreq_o),
      .excp_jump_o     (excp_jump_o),
      .excp_jump_addr_o(excp_jump_addr_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic clear_flags();
      id_ecall_i   = 1'b0;
      id_ebreak_i  = 1'b0;
      id_illegal_i = 1'b0;
      id_mret_i    = 1'b0;
   endtask

   task automatic check_idle_quiet(input string tag);
      check({tag, " stall"}, 32'(excp_stallreq_o), 32'd0);
      check({tag, " we"},    32'(csr_we_o),        32'd0);
      check({tag, " jump"},  32'(excp_jump_o),     32'd0);
      check({tag, " flush"}, 32'(excp_flushreq_o), 32'd0);
   endtask

   // Caller drives the detect-cycle inputs; this walks T..T+5 and ends in JUMP.
   task automatic run_trap(input string tag, input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] mst,
                           input logic [31:0] target, input logic [2:0] flush,
                           input bit drop_irq);
      #1;
      check({tag, " T stall"}, 32'(excp_stallreq_o), 32'd1);
      check({tag, " T we"},    32'(csr_we_o),        32'd0);
      tick();
      clear_flags();
      id_pc_i = pc + 32'd4;
      if (drop_irq) irq_timer_i = 1'b0;
      #1;
      check({tag, " mepc we"},    32'(csr_we_o),        32'd1);
      check({tag, " mepc addr"},  32'(csr_waddr_o),     32'h341);
      check({tag, " mepc data"},  csr_wdata_o,          pc);
      check({tag, " mepc stall"}, 32'(excp_stallreq_o), 32'd1);
      tick(); #1;
      check({tag, " mcause addr"}, 32'(csr_waddr_o), 32'h342);
      check({tag, " mcause data"}, csr_wdata_o,      cause);
      tick(); #1;
      check({tag, " mtval addr"}, 32'(csr_waddr_o), 32'h343);
      check({tag, " mtval data"}, csr_wdata_o,      tval);
      tick(); #1;
      check({tag, " mstatus addr"},  32'(csr_waddr_o),     32'h300);
      check({tag, " mstatus data"},  csr_wdata_o,          mst);
      check({tag, " mstatus stall"}, 32'(excp_stallreq_o), 32'd1);
      tick(); #1;
      check({tag, " jump"},       32'(excp_jump_o),     32'd1);
      check({tag, " jump addr"},  excp_jump_addr_o,     target);
      check({tag, " jump flush"}, 32'(excp_flushreq_o), 32'(flush));
      check({tag, " jump stall"}, 32'(excp_stallreq_o), 32'd0);
      check({tag, " jump we"},    32'(csr_we_o),        32'd0);
   endtask

   initial begin
      rst_i = 1'b1;
      id_valid_i = 1'b0; id_pc_i = '0; id_inst_i = '0;
      clear_flags();
      irq_timer_i = 1'b0;
      csr_mstatus_i = '0; csr_mie_i = '0; csr_mtvec_i = '0; csr_mepc_i = '0;
      tick(); tick();
      rst_i = 1'b0;
      #1;
      check_idle_quiet("reset");

      // ecall at 0x100: mstatus 0x8 -> MPIE=1, MIE=0, MPP=3 -> 0x1880
      tick();
      csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8;
      id_valid_i = 1'b1; id_pc_i = 32'h100; id_ecall_i = 1'b1;
      run_trap("ecall", 32'h100, 32'd11, 32'h0, 32'h1880, 32'h200, 3'b010, 1'b0);
      id_valid_i = 1'b0;
      tick(); #1;
      check_idle_quiet("ecall after");

      // illegal beats ecall
      id_valid_i = 1'b1; id_pc_i = 32'h40; id_inst_i = 32'hFFFF_FFFF;
      id_illegal_i = 1'b1; id_ecall_i = 1'b1;
      run_trap("illegal", 32'h40, 32'd2, 32'hFFFF_FFFF, 32'h1880, 32'h200, 3'b010, 1'b0);
      id_valid_i = 1'b0;
      tick();

      // vectored timer interrupt: 0x300 + 4*7 = 0x31C; irq drops mid-sequence
      id_valid_i = 1'b1; id_pc_i = 32'h80; irq_timer_i = 1'b1;
      csr_mstatus_i = 32'h8; csr_mie_i = 32'h80; csr_mtvec_i = 32'h301;
      run_trap("irq", 32'h80, 32'h8000_0007, 32'h0, 32'h1880, 32'h31C, 3'b001, 1'b1);
      tick(); #1;
      check_idle_quiet("irq after");

      // interrupt masked by mstatus.MIE=0
      irq_timer_i = 1'b1; csr_mstatus_i = 32'h0; id_pc_i = 32'h80;
      #1;
      check_idle_quiet("irq masked T");
      tick(); #1;
      check_idle_quiet("irq masked T+1");
      irq_timer_i = 1'b0;

      // mret: mstatus 0x80 -> MIE=MPIE=1, MPIE=1 -> 0x88
      tick();
      csr_mepc_i = 32'h144; csr_mstatus_i = 32'h80;
      id_valid_i = 1'b1; id_pc_i = 32'h60; id_mret_i = 1'b1;
      #1;
      check("mret T stall", 32'(excp_stallreq_o), 32'd1);
      check("mret T we",    32'(csr_we_o),        32'd0);
      tick();
      clear_flags(); id_valid_i = 1'b0;
      #1;
      check("mret mstatus we",    32'(csr_we_o),        32'd1);
      check("mret mstatus addr",  32'(csr_waddr_o),     32'h300);
      check("mret mstatus data",  csr_wdata_o,          32'h88);
      check("mret mstatus stall", 32'(excp_stallreq_o), 32'd1);
      tick(); #1;
      check("mret jump",       32'(excp_jump_o),     32'd1);
      check("mret jump addr",  excp_jump_addr_o,     32'h144);
      check("mret jump flush", 32'(excp_flushreq_o), 32'd4);
      check("mret jump stall", 32'(excp_stallreq_o), 32'd0);
      tick(); #1;
      check_idle_quiet("mret after");

      // ecall wins over a pending interrupt; interrupt then taken right after JUMP
      csr_mstatus_i = 32'h8; csr_mie_i = 32'h80; csr_mtvec_i = 32'h301;
      irq_timer_i = 1'b1; id_valid_i = 1'b1; id_pc_i = 32'h100; id_ecall_i = 1'b1;
      run_trap("ecall+irq", 32'h100, 32'd11, 32'h0, 32'h1880, 32'h300, 3'b010, 1'b0);
      tick();
      run_trap("b2b irq", 32'h104, 32'h8000_0007, 32'h0, 32'h1880, 32'h31C, 3'b001, 1'b1);
      id_valid_i = 1'b0;
      tick();

      // reset while in W_MCAUSE
      csr_mtvec_i = 32'h200;
      id_valid_i = 1'b1; id_pc_i = 32'h100; id_ecall_i = 1'b1;
      tick();
      clear_flags(); id_valid_i = 1'b0;
      tick(); #1;
      check("pre-reset mcause addr", 32'(csr_waddr_o), 32'h342);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1;
      check_idle_quiet("post-reset");
      tick(); #1;
      check_idle_quiet("post-reset+1");
      tick(); #1;
      check("post-reset+2 we", 32'(csr_we_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/excp_ctrl.md
Name: excp_ctrl

Overview:
- Machine-mode trap sequencer for the in-order pipeline.
- Detects synchronous exceptions (ecall, ebreak, illegal instruction), the machine timer interrupt, and mret on the instruction in decode.
- Writes mepc/mcause/mtval/mstatus through a single CSR write port over several cycles, then redirects fetch.
- Drives excp_stallreq_o / excp_flushreq_o[2:0] into the pipeline controller, which turns them into stall/flush vectors for the pipeline registers.

Parameters:
DW, 32, datapath/CSR width
VECTORED_EN, 1, 1 = honour mtvec vectored mode for interrupts; 0 = always direct

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_valid_i  in  1  decode holds a valid instruction
id_pc_i  in  DW  pc of decode instruction
id_inst_i  in  32  raw decode instruction
id_ecall_i  in  1  instruction is ecall
id_ebreak_i  in  1  instruction is ebreak
id_illegal_i  in  1  instruction is illegal
id_mret_i  in  1  instruction is mret
irq_timer_i  in  1  machine timer interrupt pending (level)
csr_mstatus_i  in  DW  current mstatus
csr_mie_i  in  DW  current mie
csr_mtvec_i  in  DW  current mtvec
csr_mepc_i  in  DW  current mepc
csr_we_o  out  1  CSR write enable
csr_waddr_o  out  12  CSR write address
csr_wdata_o  out  DW  CSR write data
excp_stallreq_o  out  1  hold pc/if/id while sequencing
excp_flushreq_o  out  3  [0] interrupt entry, [1] exception entry, [2] mret return
excp_jump_o  out  1  redirect fetch this cycle
excp_jump_addr_o  out  DW  redirect target

Behaviour:
- Reset: state IDLE; latched pc/cause/tval/kind cleared. All outputs 0 while state is IDLE, except excp_stallreq_o as defined below.
- States: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, JUMP. Trap path: IDLE->W_MEPC->W_MCAUSE->W_MTVAL->W_MSTATUS->JUMP->IDLE. Mret path: IDLE->W_MSTATUS->JUMP->IDLE.
- Detection happens in IDLE only, and only when id_valid_i=1.
- Priority: illegal > ebreak > ecall > timer interrupt > mret.
- Interrupt is taken only when irq_timer_i & mstatus.MIE(bit3) & mie.MTIE(bit7).
- On detect cycle T: latch pc=id_pc_i, kind, cause, tval. Inputs are ignored until the FSM returns to IDLE.
- Causes: illegal=2, tval=id_inst_i; ebreak=3, tval=id_pc_i; ecall=11, tval=0; timer=0x80000007, tval=0.
- excp_stallreq_o (combinational):
  - 1 in IDLE on the detect cycle;
  - 1 in every W_* state;
  - 0 in JUMP and otherwise.
- CSR writes (one per state, csr_we_o=1):
  - W_MEPC: 0x341 <= latched pc.
  - W_MCAUSE: 0x342 <= cause.
  - W_MTVAL: 0x343 <= tval.
  - W_MSTATUS, trap: 0x300 <= mstatus_i with MPIE(bit7)=MIE, MIE=0, MPP(bits12:11)=2'b11.
  - W_MSTATUS, mret: 0x300 <= mstatus_i with MIE=MPIE, MPIE=1.
  - csr_wdata_o uses csr_mstatus_i sampled in that state.
- JUMP, single cycle:
  - excp_jump_o=1.
  - excp_flushreq_o one-hot per kind: interrupt 3'b001, exception 3'b010, mret 3'b100.
  - Target: mret -> csr_mepc_i; trap -> {mtvec[DW-1:2],2'b00}. If VECTORED_EN and mtvec[1:0]==2'b01 and interrupt -> base + 4*7.
- Latency: trap jump at T+5 with stall T..T+4; mret jump at T+2 with stall T..T+1.
- Interrupt mepc = pc of the un-executed decode instruction, which is flushed by flushreq[0].
- Back-to-back events: the FSM may detect a new event in the IDLE cycle immediately after JUMP. During JUMP, detection is suppressed.
- irq dropping mid-sequence has no effect on the sequence.
- Reset asserted in any state returns to IDLE next edge. No partial CSR write completes after reset.

Test Plan:
- Reset mid-W_MCAUSE -> next cycle all outputs 0, state IDLE, no further csr_we_o.
- ecall at pc 0x100, mtvec 0x200, mstatus 0x8 -> writes mepc 0x100, mcause 11, mtval 0, mstatus 0x1880 at T+1..T+4. T+5: jump to 0x200, flushreq=3'b010. Stall T..T+4.
- Illegal inst 0xFFFFFFFF at pc 0x40 with ecall also set -> mcause 2, mtval 0xFFFFFFFF.
- irq_timer_i=1, MIE=1, MTIE=1, mtvec 0x301, pc 0x80 -> mepc 0x80, mcause 0x80000007, jump 0x31C, flushreq=3'b001. Repeat with MIE=0 -> no action, stall 0.
- mret, mepc 0x144, mstatus 0x80 -> T+1 writes mstatus 0x88. T+2: jump 0x144, flushreq=3'b100, stall T..T+1.
- Interrupt pending while ecall in decode -> ecall wins. Interrupt is taken in the first eligible IDLE cycle after JUMP.
